// File: rtl/serial_logic_unit.sv
// Bit-serial AND/OR/XOR/NAND unit: one result bit per clock, LSB first, N-bit result plus zero flag.
// Latency: N cycles from the accept edge until out_valid; one request in flight at a time.
// Backpressure: in_ready is low until the result is taken; the result is held while out_ready is low.
module serial_logic_unit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [1:0]     op_reg;
    logic [N-1:0]   acc;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last;
    logic           bit_out;
    logic [N:0]     acc_ext;
    logic [N-1:0]   acc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs depend on state only, never on the inputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_ready && in_valid;
    assign last   = (cnt == CW'(N - 1));

    always_comb begin
        bit_out = 1'b0;
        case (op_reg)
            2'b00:   bit_out = a_reg[0] & b_reg[0];
            2'b01:   bit_out = a_reg[0] | b_reg[0];
            2'b10:   bit_out = a_reg[0] ^ b_reg[0];
            default: bit_out = ~(a_reg[0] & b_reg[0]);
        endcase
    end

    // New bit enters at the MSB; after N shifts bit 0 of the operands sits at bit 0.
    assign acc_ext = {bit_out, acc};
    assign acc_nxt = acc_ext[N:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 2'b00;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else if (accept) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            acc   <= acc_nxt;
            cnt   <= cnt + CW'(1);
            if (last) begin
                result <= acc_nxt;
                zero   <= ~|acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Randomized and directed bench for serial_logic_unit against a transaction-level model.
module tb_serial_logic_unit;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0       = 0;

    // Model state: operands captured at accept, edges still to go, finished result.
    logic [N-1:0] pa = '0;
    logic [N-1:0] pb = '0;
    logic [1:0]   pop = 2'b00;
    int           left = 0;
    bit           m_done = 1'b0;
    logic [N-1:0] m_res = '0;
    bit           m_zero = 1'b1;
    bit           chk_en = 1'b0;

    serial_logic_unit #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] f(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            left   <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_zero <= 1'b1;
            chk_en <= 1'b1;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) begin
                m_res  <= f(pa, pb, pop);
                m_zero <= (f(pa, pb, pop) == '0);
                m_done <= 1'b1;
            end
        end else if (in_valid) begin
            pa   <= a;
            pb   <= b;
            pop  <= op;
            left <= N;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(left == 0 && !m_done));
            chk("out_valid", 32'(out_valid), 32'(m_done));
            chk("result", 32'(result), 32'(m_res));
            chk("zero", 32'(zero), 32'(m_zero));
        end
    end

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic [1:0] top);
        int g = 0;
        in_valid = 1'b1;
        a = ta;
        b = tbv;
        op = top;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready never rose");
        end
        @(negedge clk);
        c0 = cyc;
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        op = 2'($urandom);
    endtask

    task automatic wait_result(input string name, input logic [N-1:0] exp, input logic expz);
        int g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            a = N'($urandom);
            b = N'($urandom);
            g++;
        end
        if (!out_valid) begin
            failures++;
            $display("FAIL %s_timeout: out_valid never rose", name);
        end else begin
            chk({name, "_latency"}, 32'(cyc - c0), 32'(N));
            chk({name, "_result"}, 32'(result), 32'(exp));
            chk({name, "_zero"}, 32'(zero), 32'(expz));
            if (out_ready) begin
                @(negedge clk);
                chk({name, "_ov_one_cycle"}, 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'h00);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(8'h96, 8'hAA, 2'b00);
        chk("and_in_ready_shift", 32'(in_ready), 32'd0);
        wait_result("and", 8'h82, 1'b0);
        send(8'h96, 8'hAA, 2'b01);
        wait_result("or", 8'hBE, 1'b0);
        send(8'h96, 8'hAA, 2'b10);
        wait_result("xor", 8'h3C, 1'b0);
        send(8'h96, 8'hAA, 2'b11);
        wait_result("nand", 8'h7D, 1'b0);

        send(8'hF0, 8'h0F, 2'b00);
        wait_result("zero_and", 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 2'b10);
        wait_result("zero_xor", 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 2'b11);
        wait_result("zero_nand", 8'h00, 1'b1);

        // Backpressure with a stray request held during DONE.
        out_ready = 1'b0;
        send(8'h96, 8'hAA, 2'b00);
        wait_result("bp", 8'h82, 1'b0);
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        op = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_result", 32'(result), 32'h82);
            chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_hs_out_valid", 32'(out_valid), 32'd0);
        chk("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        c0 = cyc;
        chk("bp_held_req_accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_result("bp_next", 8'h33, 1'b0);

        // Reset on the third SHIFT edge discards the operation.
        send(8'h96, 8'hAA, 2'b01);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'h00);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(8'h0F, 8'hFF, 2'b10);
        wait_result("after_rst_xor", 8'hF0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = N'($urandom);
            b = N'($urandom);
            op = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
